lm_sm_seq: RTL



---
 rtl/lm_sm_seq_if.sv | 28 ++
 rtl/lm_sm_seq.sv | 123 ++++++++++++
 2 files changed

// File: rtl/lm_sm_seq_if.sv
// Bundle between the MEM-stage pipeline and the multi-register sequencer.
// The master side presents the instruction and base address. The slave
// side (the sequencer) returns the register index, the memory strobes and
// the pipeline stall.
interface lm_sm_seq_if;
  logic [15:0] instr_in;
  logic        valid_in;
  logic [15:0] base_in;
  logic        flush;
  logic [2:0]  k_mem;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic        rf_we;
  logic        stall_up;
  logic        busy;
  logic        done;

  modport master (
    output instr_in, valid_in, base_in, flush,
    input  k_mem, mem_addr, mem_re, mem_we, rf_we, stall_up, busy, done
  );

  modport slave (
    input  instr_in, valid_in, base_in, flush,
    output k_mem, mem_addr, mem_re, mem_we, rf_we, stall_up, busy, done
  );
endinterface

// File: rtl/lm_sm_seq.sv
// Memory-stage sequencer for LM/SM/LA/SA. It issues one data-memory access
// per selected register, lowest index first, at dense consecutive addresses
// starting at the base. The upstream pipeline is stalled while it runs.
module lm_sm_seq (
  input  logic         clk,
  input  logic         rst_n,
  lm_sm_seq_if.slave   bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  state_reg, state_next;
  logic [7:0]  mask_reg, mask_next;
  logic [15:0] base_reg, base_next;
  logic [2:0]  offset_reg, offset_next;
  logic        is_load_reg, is_load_next;

  logic [3:0]  opcode;
  logic        is_multi;
  logic [7:0]  dec_mask;
  logic        accept;
  logic        zero_mask_hit;
  logic [2:0]  k_low;
  logic [7:0]  mask_rest;
  logic        last_access;

  // Decode of the instruction waiting at the MEM input
  assign opcode        = bus.instr_in[15:12];
  assign is_multi      = (opcode[3:2] == 2'b11);
  assign dec_mask      = opcode[1] ? 8'h7F : bus.instr_in[7:0];
  assign accept        = bus.valid_in && is_multi && (dec_mask != 8'h00) && !bus.flush;
  assign zero_mask_hit = bus.valid_in && is_multi && (dec_mask == 8'h00) && !bus.flush;

  // Lowest remaining selected register; the scan runs high to low so the last hit wins
  always_comb begin
    k_low = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_reg[i]) k_low = i[2:0];
    end
  end

  // Clearing the lowest set bit leaves nothing when this is the final access
  assign mask_rest   = mask_reg & (mask_reg - 8'd1);
  assign last_access = (mask_rest == 8'h00);

  // Next-state logic: accept in IDLE, walk the mask in RUN, and flush wins over both
  always_comb begin
    state_next   = state_reg;
    mask_next    = mask_reg;
    base_next    = base_reg;
    offset_next  = offset_reg;
    is_load_next = is_load_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next   = ST_RUN;
          mask_next    = dec_mask;
          base_next    = bus.base_in;
          offset_next  = 3'd0;
          is_load_next = ~opcode[0];
        end
      end
      default: begin
        if (bus.flush) begin
          state_next  = ST_IDLE;
          mask_next   = 8'h00;
          offset_next = 3'd0;
        end else begin
          mask_next   = mask_rest;
          offset_next = offset_reg + 3'd1;
          if (last_access) state_next = ST_IDLE;
        end
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      mask_reg    <= 8'h00;
      base_reg    <= 16'h0000;
      offset_reg  <= 3'd0;
      is_load_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mask_reg    <= mask_next;
      base_reg    <= base_next;
      offset_reg  <= offset_next;
      is_load_reg <= is_load_next;
    end
  end

  // Output decode: the strobes come only from state. The exception is the
  // zero-mask done pulse, which must appear in the accept cycle itself.
  always_comb begin
    bus.k_mem    = 3'd0;
    bus.mem_addr = 16'h0000;
    bus.mem_re   = 1'b0;
    bus.mem_we   = 1'b0;
    bus.rf_we    = 1'b0;
    bus.stall_up = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    if (state_reg == ST_RUN) begin
      bus.busy     = 1'b1;
      bus.stall_up = 1'b1;
      bus.k_mem    = k_low;
      bus.mem_addr = base_reg + {13'd0, offset_reg};
      if (!bus.flush) begin
        bus.mem_re = is_load_reg;
        bus.rf_we  = is_load_reg;
        bus.mem_we = ~is_load_reg;
        bus.done   = last_access;
      end
    end else begin
      // Reset gating keeps every output at 0 while reset is asserted
      bus.done = rst_n && zero_mask_hit;
    end
  end

endmodule
